// File: rtl/exp_job_arbiter.sv
// exp_job_arbiter: shares one exponent FSMD unit between two requesters.
// Accepts (a, n) jobs over valid/ready, runs the unit through a go/done
// sequence with a watchdog, and returns a tagged 16-bit result over a
// response handshake.
// Optional feature macro: EXP_ARB_RR_EN selects round-robin arbitration.
// When it is not defined, req0 always has priority over req1.
module exp_job_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 1023,
  parameter int unsigned CNT_W          = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [7:0]  req0_n,
  input  logic [7:0]  req0_a,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [7:0]  req1_n,
  input  logic [7:0]  req1_a,
  output logic        exp_go_o,
  output logic [7:0]  exp_n_o,
  output logic [7:0]  exp_a_o,
  input  logic [15:0] exp_result_i,
  input  logic        exp_done_i,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [15:0] rsp_data,
  output logic        rsp_timeout,
  output logic        busy
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  localparam logic [CNT_W-1:0] WD_LIMIT = CNT_W'(TIMEOUT_CYCLES);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] wd_q, wd_d;
  logic [7:0]       n_q, n_d;
  logic [7:0]       a_q, a_d;
  logic             id_q, id_d;
  logic [15:0]      data_q, data_d;
  logic             to_q, to_d;
  logic             busy_q;
  logic             grant0, grant1;
  logic             accept;

`ifdef EXP_ARB_RR_EN
  logic last_q, last_d;

  // Round-robin: on contention the requester not granted last time wins
  always_comb begin
    grant0 = req0_valid && (!req1_valid || last_q);
    grant1 = req1_valid && (!req0_valid || !last_q);
    last_d = last_q;
    if (accept) begin
      last_d = grant1;
    end
  end

  // Last-grant pointer; reset value 1 lets req0 win the first contention
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end
`else
  // Fixed priority: req0 always beats req1
  always_comb begin
    grant0 = req0_valid;
    grant1 = req1_valid && !req0_valid;
  end
`endif

  // Readies are gated by rst so they read 0 while reset is held
  always_comb begin
    accept     = (state_q == ST_IDLE) && rst && (grant0 || grant1);
    req0_ready = (state_q == ST_IDLE) && rst && grant0;
    req1_ready = (state_q == ST_IDLE) && rst && grant1;
  end

  // Next-state and datapath updates for the job sequencer.
  // wd_q is 0 only in the first WAIT cycle, so it doubles as the
  // stale-done mask without a separate flag.
  always_comb begin
    state_d = state_q;
    wd_d    = wd_q;
    n_d     = n_q;
    a_d     = a_q;
    id_d    = id_q;
    data_d  = data_q;
    to_d    = to_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          n_d     = grant0 ? req0_n : req1_n;
          a_d     = grant0 ? req0_a : req1_a;
          id_d    = grant1;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        wd_d    = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if ((wd_q != '0) && exp_done_i) begin
          data_d  = exp_result_i;
          to_d    = 1'b0;
          state_d = ST_RESP;
        end else if (wd_q == WD_LIMIT) begin
          data_d  = '1;
          to_d    = 1'b1;
          state_d = ST_RESP;
        end else begin
          wd_d = wd_q + CNT_W'(1);
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, watchdog, latched job and response registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      wd_q    <= '0;
      n_q     <= '0;
      a_q     <= '0;
      id_q    <= 1'b0;
      data_q  <= '0;
      to_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wd_q    <= wd_d;
      n_q     <= n_d;
      a_q     <= a_d;
      id_q    <= id_d;
      data_q  <= data_d;
      to_q    <= to_d;
      busy_q  <= (state_d != ST_IDLE);
    end
  end

  // Output decode
  always_comb begin
    exp_go_o    = (state_q == ST_ISSUE);
    exp_n_o     = n_q;
    exp_a_o     = a_q;
    rsp_valid   = (state_q == ST_RESP);
    rsp_id      = id_q;
    rsp_data    = data_q;
    rsp_timeout = to_q;
    busy        = busy_q;
  end

endmodule

// File: tb/tb_exp_job_arbiter.sv
// Testbench for exp_job_arbiter with a behavioural exponent unit model and
// a scoreboard of expected responses.
module tb_exp_job_arbiter;

  localparam int TMO = 8;
  localparam int LAT = 6;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [7:0]  req0_n = '0, req0_a = '0, req1_n = '0, req1_a = '0;
  logic        exp_go_o;
  logic [7:0]  exp_n_o, exp_a_o;
  logic [15:0] exp_result_i;
  logic        exp_done_i;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic        rsp_id;
  logic [15:0] rsp_data;
  logic        rsp_timeout;
  logic        busy;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        id;
    logic [15:0] data;
    logic        to;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  exp_job_arbiter #(.TIMEOUT_CYCLES(TMO), .CNT_W(10)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_n(req0_n), .req0_a(req0_a),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_n(req1_n), .req1_a(req1_a),
    .exp_go_o(exp_go_o), .exp_n_o(exp_n_o), .exp_a_o(exp_a_o),
    .exp_result_i(exp_result_i), .exp_done_i(exp_done_i),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_timeout(rsp_timeout), .busy(busy)
  );

  function automatic logic [15:0] pw(input logic [7:0] a, input logic [7:0] n);
    logic [15:0] r;
    r = 16'd1;
    for (int i = 0; i < int'(n); i++) r = r * {8'd0, a};
    return r;
  endfunction

  // Exponent unit model: done LAT cycles after go; optional stale done on
  // the go cycle and the one after; optional never-done mode.
  int          m_cnt = 0;
  int          m_stale = 0;
  logic [15:0] m_res = '0;
  bit          m_never = 0;
  bit          m_stale_en = 0;

  initial begin
    exp_done_i   = 1'b0;
    exp_result_i = '0;
    forever begin
      @(posedge clk); #1;
      if (!rst) begin
        m_cnt = 0; m_stale = 0; exp_done_i = 1'b0; exp_result_i = '0;
      end else if (exp_go_o) begin
        m_res = pw(exp_a_o, exp_n_o);
        m_cnt = m_never ? 0 : LAT;
        if (m_stale_en) begin
          exp_done_i = 1'b1; exp_result_i = 16'hDEAD; m_stale = 1;
        end else begin
          exp_done_i = 1'b0;
        end
      end else begin
        exp_done_i = 1'b0;
        if (m_stale > 0) begin
          exp_done_i = 1'b1; exp_result_i = 16'hDEAD; m_stale--;
        end
        if (m_cnt > 0) begin
          m_cnt--;
          if (m_cnt == 0) begin exp_done_i = 1'b1; exp_result_i = m_res; end
        end
      end
    end
  end

  // Presents a job; returns whether it was granted. Ends at posedge+1 of T+1.
  task automatic start_job(input bit id, input logic [7:0] a, input logic [7:0] n, output bit got);
    if (id) begin req1_valid = 1'b1; req1_a = a; req1_n = n; end
    else    begin req0_valid = 1'b1; req0_a = a; req0_n = n; end
    @(negedge clk);
    got = id ? req1_ready : req0_ready;
    if (got) sb.push_back('{id, pw(a, n), 1'b0});
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  // Waits (bounded) for rsp_valid; counts cycles and go pulses seen.
  task automatic wait_rsp(input int max, output bit ok, output int cyc, output int gos);
    ok = 0; cyc = 0; gos = 0;
    while (cyc < max) begin
      @(posedge clk); #1;
      cyc++;
      if (exp_go_o) gos++;
      if (rsp_valid) begin ok = 1; break; end
    end
  endtask

  task automatic take_rsp();
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    logic [38:0] v;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    @(negedge clk);
    v = {exp_go_o, exp_n_o, exp_a_o, rsp_valid, rsp_id, rsp_data, rsp_timeout, busy, req0_ready, req1_ready};
    checks++; if (v !== 39'd0) begin errors++; $display("FAIL reset_outputs: got %h want 0", v); end
    req0_valid = 1'b0; req1_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_single();
    bit ok, got; int cyc, gos; exp_t e;
    start_job(1'b0, 8'd5, 8'd3, got);
    checks++; if (got !== 1'b1) begin errors++; $display("FAIL single_grant: got %b want 1", got); end
    checks++; if (exp_go_o !== 1'b1) begin errors++; $display("FAIL single_go_T1: got %b want 1", exp_go_o); end
    checks++; if ({exp_n_o, exp_a_o} !== {8'd3, 8'd5}) begin errors++; $display("FAIL single_operands: got %h want 0305", {exp_n_o, exp_a_o}); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b want 1", busy); end
    wait_rsp(50, ok, cyc, gos);
    checks++; if (!ok) begin errors++; $display("FAIL single_rsp_wait: got no response want rsp_valid"); end
    checks++; if (1 + cyc !== 8) begin errors++; $display("FAIL single_latency: got %0d want 8", 1 + cyc); end
    checks++; if (gos !== 0) begin errors++; $display("FAIL single_go_once: got %0d extra pulses want 0", gos); end
    if (ok) begin
      checks++;
      if (sb.size() == 0) begin errors++; $display("FAIL single_sb: got response want none"); end
      else begin
        e = sb.pop_front();
        if ({rsp_id, rsp_data, rsp_timeout} !== {e.id, e.data, e.to}) begin
          errors++; $display("FAIL single_rsp: got id=%b data=%0d to=%b want id=%b data=%0d to=%b",
                             rsp_id, rsp_data, rsp_timeout, e.id, e.data, e.to);
        end
      end
    end
    take_rsp();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_back_idle: got busy=%b want 0", busy); end
  endtask

  task automatic test_contention();
    int i0, i1, g, r, cyc;
    logic exp_gid;
    exp_t e;
    i0 = 0; i1 = 0; g = 0; r = 0; cyc = 0;
    while (r < 8 && cyc < 1000) begin
      req0_valid = (i0 < 4); req0_n = 8'(i0 + 1); req0_a = 8'd2;
      req1_valid = (i1 < 4); req1_n = 8'(i1 + 1); req1_a = 8'd3;
      rsp_ready = rsp_valid;
      if (rsp_valid) begin
        checks++;
        if (sb.size() == 0) begin errors++; $display("FAIL cont_sb: got unexpected response data=%0d", rsp_data); end
        else begin
          e = sb.pop_front();
          if ({rsp_id, rsp_data, rsp_timeout} !== {e.id, e.data, e.to}) begin
            errors++; $display("FAIL cont_rsp%0d: got id=%b data=%0d to=%b want id=%b data=%0d to=%b",
                               r, rsp_id, rsp_data, rsp_timeout, e.id, e.data, e.to);
          end
        end
        r++;
      end
      @(negedge clk);
      if (req0_ready || req1_ready) begin
        checks++; if (req0_ready && req1_ready) begin errors++; $display("FAIL cont_one_ready: got both want one"); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL cont_ready_idle: got busy=%b want 0", busy); end
`ifdef EXP_ARB_RR_EN
        exp_gid = g[0];
`else
        exp_gid = (g >= 4);
`endif
        checks++;
        if (req1_ready !== exp_gid) begin errors++; $display("FAIL cont_grant%0d: got %b want %b", g, req1_ready, exp_gid); end
        if (req0_ready) begin sb.push_back('{1'b0, pw(8'd2, 8'(i0 + 1)), 1'b0}); i0++; end
        else            begin sb.push_back('{1'b1, pw(8'd3, 8'(i1 + 1)), 1'b0}); i1++; end
        g++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
    checks++; if (r !== 8) begin errors++; $display("FAIL cont_count: got %0d responses want 8", r); end
  endtask

  task automatic test_timeout();
    bit ok, got; int cyc, gos; exp_t e;
    m_never = 1;
    start_job(1'b1, 8'd9, 8'd9, got);
    sb.delete();
    sb.push_back('{1'b1, 16'hFFFF, 1'b1});
    checks++; if (got !== 1'b1) begin errors++; $display("FAIL tmo_grant: got %b want 1", got); end
    wait_rsp(50, ok, cyc, gos);
    checks++; if (1 + cyc !== TMO + 3) begin errors++; $display("FAIL tmo_latency: got %0d want %0d", 1 + cyc, TMO + 3); end
    checks++; if ({exp_n_o, exp_a_o} !== 16'h0909) begin errors++; $display("FAIL tmo_operand_hold: got %h want 0909", {exp_n_o, exp_a_o}); end
    if (ok) begin
      e = sb.pop_front();
      checks++;
      if ({rsp_id, rsp_data, rsp_timeout} !== {e.id, e.data, e.to}) begin
        errors++; $display("FAIL tmo_rsp: got id=%b data=%h to=%b want id=%b data=%h to=%b",
                           rsp_id, rsp_data, rsp_timeout, e.id, e.data, e.to);
      end
    end
    take_rsp();
    m_never = 0;
    start_job(1'b0, 8'd4, 8'd2, got);
    wait_rsp(50, ok, cyc, gos);
    checks++; if (!ok) begin errors++; $display("FAIL tmo_next_wait: got no response want rsp_valid"); end
    if (ok && sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if ({rsp_id, rsp_data, rsp_timeout} !== {e.id, e.data, e.to}) begin
        errors++; $display("FAIL tmo_next_rsp: got id=%b data=%0d to=%b want id=%b data=%0d to=%b",
                           rsp_id, rsp_data, rsp_timeout, e.id, e.data, e.to);
      end
    end
    take_rsp();
  endtask

  task automatic test_stale_backpressure();
    bit ok, got; int cyc, gos; exp_t e;
    m_stale_en = 1;
    start_job(1'b0, 8'd3, 8'd4, got);
    wait_rsp(50, ok, cyc, gos);
    m_stale_en = 0;
    checks++; if (1 + cyc !== 8) begin errors++; $display("FAIL stale_latency: got %0d want 8", 1 + cyc); end
    if (ok && sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if ({rsp_id, rsp_data, rsp_timeout} !== {e.id, e.data, e.to}) begin
        errors++; $display("FAIL stale_rsp: got id=%b data=%h to=%b want id=%b data=%h to=%b",
                           rsp_id, rsp_data, rsp_timeout, e.id, e.data, e.to);
      end
    end
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      checks++;
      if ({rsp_valid, rsp_id, rsp_data, rsp_timeout, busy, req0_ready, req1_ready} !== {1'b1, 1'b0, 16'd81, 1'b0, 1'b1, 1'b0, 1'b0}) begin
        errors++; $display("FAIL bp_hold%0d: got v=%b id=%b d=%0d to=%b busy=%b r0=%b r1=%b want v=1 id=0 d=81 to=0 busy=1 r0=0 r1=0",
                           k, rsp_valid, rsp_id, rsp_data, rsp_timeout, busy, req0_ready, req1_ready);
      end
      @(posedge clk); #1;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    take_rsp();
  endtask

  task automatic test_reset_mid_wait();
    bit ok, got, seen; int cyc, gos; exp_t e;
    logic [38:0] v;
    start_job(1'b1, 8'd6, 8'd3, got);
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++; if ({busy, rsp_valid} !== 2'b10) begin errors++; $display("FAIL rmw_in_wait: got busy/rsp=%b want 10", {busy, rsp_valid}); end
    rst = 1'b0; req0_valid = 1'b1;
    m_cnt = 0; m_stale = 0; exp_done_i = 1'b0;
    #1;
    v = {exp_go_o, exp_n_o, exp_a_o, rsp_valid, rsp_id, rsp_data, rsp_timeout, busy, req0_ready, req1_ready};
    checks++; if (v !== 39'd0) begin errors++; $display("FAIL rmw_async_zero: got %h want 0", v); end
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b1; req0_valid = 1'b0;
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (rsp_valid) seen = 1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rmw_no_rsp: got response want none"); end
    start_job(1'b0, 8'd7, 8'd2, got);
    wait_rsp(50, ok, cyc, gos);
    checks++; if (!ok) begin errors++; $display("FAIL rmw_next_wait: got no response want rsp_valid"); end
    if (ok && sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if ({rsp_id, rsp_data, rsp_timeout} !== {e.id, e.data, e.to}) begin
        errors++; $display("FAIL rmw_next_rsp: got id=%b data=%0d to=%b want id=%b data=%0d to=%b",
                           rsp_id, rsp_data, rsp_timeout, e.id, e.data, e.to);
      end
    end
    take_rsp();
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_timeout();
    test_stale_backpressure();
    test_reset_mid_wait();
    checks++; if (sb.size() !== 0) begin errors++; $display("FAIL sb_empty: got %0d pending want 0", sb.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no completion want finish");
    $fatal(1, "simulation time limit reached");
  end

endmodule

// File: doc/exp_job_arbiter.md
# exp_job_arbiter

Shares one exponent FSMD unit between two requesters. Accepts jobs (base `a`, exponent `n`) through valid/ready handshakes and arbitrates round-robin between simultaneous requests. Sequences the unit through go/done, guards against a hung unit with a watchdog, and returns each tagged 16-bit result through a response handshake. It sits between the LCD/front-end logic and the exponent datapath/control pair.

## Interface
- `TIMEOUT_CYCLES`, 1023: maximum WAIT cycles before a job is aborted; range 1..2^CNT_W-1.
- `CNT_W`, 10: watchdog counter width.

- `clk` in 1: system clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `req0_valid` in 1: requester 0 has a job.
- `req0_ready` out 1: requester 0's job is accepted this cycle.
- `req0_n` in 8: requester 0 exponent.
- `req0_a` in 8: requester 0 base.
- `req1_valid`, `req1_ready`, `req1_n`, `req1_a`: same as requester 0, for requester 1.
- `exp_go_o` out 1: start pulse to the exponent unit.
- `exp_n_o` out 8: operand `n` to the unit.
- `exp_a_o` out 8: operand `a` to the unit.
- `exp_result_i` in 16: unit result.
- `exp_done_i` in 1: unit completion flag.
- `rsp_valid` out 1: response available.
- `rsp_ready` in 1: consumer accepts the response.
- `rsp_id` out 1: index of the requester that owns the response.
- `rsp_data` out 16: result, or 16'hFFFF on timeout.
- `rsp_timeout` out 1: the response is a watchdog abort.
- `busy` out 1: the arbiter is not in IDLE.

## Operation
- States:
  - IDLE: arbitrate among valid requests.
  - ISSUE: drive the start pulse.
  - WAIT: wait for done or timeout.
  - RESP: hold the response until it is taken.
- IDLE:
  - If any `reqX_valid` is high, assert `reqX_ready` combinationally for exactly one winner.
  - Latch the winner's `n`, `a` and id into internal registers, then go to ISSUE.
  - `reqX_ready` is never high outside IDLE.
  - The two ready signals are never high together.
- Arbitration:
  - With one requester valid, that requester wins.
  - With both valid, the requester not granted last time wins.
  - The last-grant pointer resets to 1, so req0 wins the first contention.
- ISSUE:
  - `exp_go_o` = 1 for exactly one cycle.
  - Go to WAIT and clear the watchdog.
- WAIT:
  - `exp_go_o` = 0.
  - `exp_done_i` is ignored in the first WAIT cycle, which masks a stale done from the prior job.
  - From the second WAIT cycle on, `exp_done_i` = 1 captures `exp_result_i` into `rsp_data`, sets `rsp_timeout` = 0, and moves to RESP.
  - Otherwise the watchdog increments.
  - When the watchdog reaches `TIMEOUT_CYCLES` without done: `rsp_data` = 16'hFFFF, `rsp_timeout` = 1, go to RESP.
  - If done and timeout occur in the same cycle, done wins.
- RESP:
  - `rsp_valid` = 1 and `rsp_id`, `rsp_data`, `rsp_timeout` are held stable.
  - `rsp_valid && rsp_ready` returns the arbiter to IDLE.
- Operand hold: `exp_n_o` and `exp_a_o` show the latched operands from ISSUE through RESP and remain stable during WAIT.
- Widths: `rsp_data` passes through unmodified; no saturation is applied. `n` = 0 is forwarded as-is; the unit defines the result.
- Reset (`rst` low, any state, asynchronous):
  - State goes to IDLE.
  - Every output is 0: `exp_go_o`, `exp_n_o`, `exp_a_o`, `rsp_valid`, `rsp_id`, `rsp_data`, `rsp_timeout`, `busy`, both readies.
  - The watchdog clears and the grant pointer is set to 1.
  - A job in flight is dropped with no response.

## Timing
- Request accepted at cycle T (IDLE, ready high).
- `exp_go_o` high at T+1; WAIT begins at T+2.
- Earliest done accepted: T+3.
- If done is sampled at cycle D, `rsp_valid` is high from D+1.
- If `rsp_ready` is high in the first RESP cycle, the arbiter is in IDLE the next cycle and can accept a new request there.
- Minimum occupancy per job: 5 cycles plus the unit's latency.
- Timeout response appears `TIMEOUT_CYCLES`+1 cycles after WAIT entry.
- `busy` is registered and equals (state != IDLE).

## Configuration
- `EXP_ARB_RR_EN` defined: round-robin arbitration as described under Operation.
- `EXP_ARB_RR_EN` undefined: fixed priority, req0 always beats req1. The grant pointer logic is removed. All other behaviour is unchanged.

## Test plan
- Single job: req0 n=3, a=5; the unit model returns 125 after 6 cycles. Required: `exp_go_o` pulses once at T+1, then rsp_id=0, rsp_data=125, rsp_timeout=0.
- Contention (RR built):
  - Both requesters hold valid for 4 jobs each (req0 a=2, n=1..4; req1 a=3, n=1..4).
  - Required: grants alternate 0,1,0,1,… starting with 0.
  - Required responses: req0 gets 2,4,8,16; req1 gets 3,9,27,81, with matching rsp_id.
  - Without `EXP_ARB_RR_EN`: all 4 req0 jobs complete first.
- Timeout: TIMEOUT_CYCLES=8 and the model never asserts done. Required: after 9 WAIT cycles, rsp_valid=1, rsp_data=16'hFFFF, rsp_timeout=1. A following job with n=2, a=4 returns 16.
- Stale done / backpressure:
  - The model holds done high for 2 cycles after go, then completes normally. Required: the stale done is ignored.
  - `rsp_ready` held low for 10 cycles. Required: the response stays stable, `busy`=1, and both readies stay 0.
- Reset mid-WAIT: assert `rst` low for 1 cycle during WAIT. Required: all outputs are 0 immediately (asynchronous), no response is ever produced, and the next job with a=7, n=2 returns 49.
